counter10_down: RTL
===================

# counter10_down

Cascadable BCD decade down-counter with parallel load, count enable, terminal-count detection and borrow output. It is the counting-down counterpart of the team's decade up-counter: it consumes and produces the same 4-bit-per-digit BCD encoding (0–9 per digit). Intended use is preset countdown timers and for reloading or draining a value that a decade up-counter produced. It sits between a control FSM (load/en) and display or decode logic (q, zero, done).

## Interface
- DIGITS, default 2: number of BCD digits; q width is 4*DIGITS.
- ONE_SHOT, default 0:
  - 0: counter wraps 0 -> all-9s and keeps counting.
  - 1: counter stops at 0 and asserts done.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  parallel-load strobe; has priority over en.
- load_val  in  4*DIGITS  BCD preset; digit i = load_val[4i+3:4i].
- en  in  1  count-down enable; one decrement per cycle while high.
- q  out  4*DIGITS  current BCD count, registered.
- zero  out  1  registered; high whenever q == 0.
- borrow  out  1  registered one-cycle pulse on wrap 0 -> all-9s (ONE_SHOT=0 only).
- load_err  out  1  registered one-cycle pulse when a loaded digit was > 9.
- done  out  1  registered; high in DONE state (ONE_SHOT=1 only, else tied 0).

## Operation
- States:
  - IDLE: entered on reset; en ignored; q holds.
  - RUN: counts on en.
  - DONE: ONE_SHOT only; q = 0, en ignored.
- Transitions:
  - Any state + load: to RUN, except when ONE_SHOT=1 and the loaded value == 0, which goes to DONE.
  - RUN + en + q == 0 + ONE_SHOT=0: wrap to all-9s; stay in RUN.
  - RUN + en + q == 1 + ONE_SHOT=1: go to DONE with q = 0.
  - Only load leaves IDLE or DONE.
- Decrement rule:
  - Digit 0 decrements on every enabled cycle.
  - Digit i > 0 decrements only when digits 0..i-1 are all 0.
  - A digit at 0 that decrements becomes 9. No binary arithmetic across digits.
- Load sanitising:
  - Each loaded digit > 9 (values 10–15) is stored as 9.
  - load_err pulses in the cycle q shows the clamped value.
  - The other digits load unchanged.
- Simultaneous load and en: load wins and no decrement occurs in that cycle.
- Outputs never hold non-BCD digits.

## Timing
- Reset (asynchronous, immediate):
  - q = 0, zero = 1, borrow = 0, load_err = 0, done = 0, state IDLE.
  - Release is sampled at the next rising clk.
- Load latency: 1 cycle. q = load_val (sanitised) after the edge that samples load = 1.
- Count latency: 1 cycle per decrement. en low holds q with no drift.
- zero and done are registered and update on the same edge as q, with no extra lag.
- borrow is high for exactly the cycle q first shows all-9s after a wrap. It is not asserted on a load of all-9s.
- Reset mid-count aborts immediately. The next load restarts normally and no stale borrow/load_err pulse appears.
- With en held high in ONE_SHOT mode, done rises on the edge q reaches 0 and stays high until load or reset.

## Test plan
- Reset then hold en = 1 for 5 cycles (DIGITS=2) -> q stays 0x00 in IDLE, zero = 1, borrow never 1.
- Load 0x42 then en = 1 for 43 cycles (ONE_SHOT=0):
  - q steps 42, 41 … 01, 00, 99.
  - zero high only in the q = 00 cycle.
  - borrow high only in the first q = 99 cycle.
- Load 0xA5 -> q = 0x95 and load_err pulses for one cycle. Load 0xFF -> q = 0x99 and load_err pulses.
- Load 0x10 and en together, then en for 2 cycles -> q = 10, 09, 08. The loaded value is not decremented in the load cycle.
- ONE_SHOT=1: load 0x03, en held high:
  - q goes 03, 02, 01, 00.
  - done rises with q = 00, and q stays 00 for 4 more cycles.
  - A subsequent load 0x07 clears done and returns to RUN.
- Assert reset asynchronously while q = 0x57 and counting -> q = 0x00, zero = 1, and all pulses go 0 before the next clk edge. After release, en is ignored until load.

Source files
------------

// File: rtl/counter10_down.sv
// counter10_down
//   Cascadable BCD decade down-counter with parallel load, count enable,
//   terminal-count detection and borrow output. Each digit is 4-bit BCD
//   (0-9). The count never leaves BCD: loaded digits above 9 are clamped to 9.
//
// Parameters
//   DIGITS    number of BCD digits (q is 4*DIGITS wide)
//   ONE_SHOT  0: wrap 0 -> all-9s and keep counting (borrow pulses on wrap)
//             1: stop at 0 and hold done until the next load or reset
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-high reset (q=0, zero=1, IDLE)
//   load      parallel-load strobe, wins over en
//   load_val  BCD preset, digit i = load_val[4i+3:4i]
//   en        count-down enable, one decrement per cycle
//   q         registered BCD count
//   zero      registered, high whenever q == 0
//   borrow    registered one-cycle pulse when q wraps 0 -> all-9s
//   load_err  registered one-cycle pulse when a loaded digit was > 9
//   done      registered, high in DONE state (ONE_SHOT=1 only)
module counter10_down #(
  parameter int DIGITS   = 2,
  parameter bit ONE_SHOT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                en,
  output logic [4*DIGITS-1:0] q,
  output logic                zero,
  output logic                borrow,
  output logic                load_err,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [4*DIGITS-1:0] q_reg, q_next;
  logic                zero_reg, zero_next;
  logic                borrow_reg, borrow_next;
  logic                load_err_reg, load_err_next;
  logic                done_reg, done_next;

  logic [4*DIGITS-1:0] q_dec;       // q_reg after one decade decrement
  logic [4*DIGITS-1:0] q_load;      // sanitised load value
  logic [DIGITS-1:0]   digit_bad;   // loaded digit i was 10..15
  // lower_zero[i]: digits 0..i-1 are all zero, so digit i takes the borrow.
  // lower_zero[DIGITS] therefore means the whole count is zero.
  logic [DIGITS:0]     lower_zero;
  logic                q_is_zero;
  logic                q_is_one;

  assign lower_zero[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      logic [3:0] raw;
      assign cur = q_reg[4*gi +: 4];
      assign raw = load_val[4*gi +: 4];

      assign lower_zero[gi+1] = lower_zero[gi] & (cur == 4'd0);

      // Each digit wraps 0 -> 9 on its own; no binary carry between digits.
      assign q_dec[4*gi +: 4] = !lower_zero[gi] ? cur :
                                (cur == 4'd0)   ? 4'd9 : cur - 4'd1;

      assign digit_bad[gi]     = (raw > 4'd9);
      assign q_load[4*gi +: 4] = digit_bad[gi] ? 4'd9 : raw;
    end
  endgenerate

  assign q_is_zero = lower_zero[DIGITS];
  assign q_is_one  = (q_reg == (4*DIGITS)'(1));

  // State and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      q_reg        <= '0;
      zero_reg     <= 1'b1;
      borrow_reg   <= 1'b0;
      load_err_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      q_reg        <= q_next;
      zero_reg     <= zero_next;
      borrow_reg   <= borrow_next;
      load_err_reg <= load_err_next;
      done_reg     <= done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    q_next        = q_reg;
    borrow_next   = 1'b0;
    load_err_next = 1'b0;

    if (load) begin
      q_next        = q_load;
      load_err_next = |digit_bad;
      // Clamping never turns a nonzero digit into zero, so testing the
      // sanitised value is equivalent to testing the raw one.
      state_next    = (ONE_SHOT && (q_load == '0)) ? DONE_ST : RUN;
    end else if (state_reg == RUN && en) begin
      if (ONE_SHOT) begin
        if (q_is_zero) begin
          state_next = DONE_ST;          // defensive: never count below zero
        end else begin
          q_next = q_dec;
          if (q_is_one) state_next = DONE_ST;
        end
      end else begin
        q_next      = q_dec;             // 0 decrements to all-9s
        borrow_next = q_is_zero;
      end
    end

    zero_next = (q_next == '0);
    done_next = ONE_SHOT && (state_next == DONE_ST);
  end

  // Outputs come straight from registers
  always_comb begin
    q        = q_reg;
    zero     = zero_reg;
    borrow   = borrow_reg;
    load_err = load_err_reg;
    done     = done_reg;
  end

endmodule
